// File: rtl/booth_seq_multiplier.sv
// Sequential radix-4 Booth multiplier: WIDTH/2 add-and-shift cycles per signed multiply.
// Optional macro MULT_UNSIGNED_EN adds an IsSigned input and a one-cycle-longer unsigned mode.
module booth_seq_multiplier #(
    parameter int WIDTH = 32
) (
    input  logic                 Clk,
    input  logic                 Reset_n,
    input  logic                 Start,
    input  logic [WIDTH-1:0]     Multiplicand,
    input  logic [WIDTH-1:0]     Multiplier,
`ifdef MULT_UNSIGNED_EN
    input  logic                 IsSigned,
`endif
    output logic [2:0]           Sel,
    output logic                 Busy,
    output logic                 Done,
    output logic [2*WIDTH-1:0]   Product
);

`ifdef MULT_UNSIGNED_EN
    localparam int QW = WIDTH + 2;
    localparam int AW = WIDTH + 4;
`else
    localparam int QW = WIDTH;
    localparam int AW = WIDTH + 2;
`endif
    localparam int CW = $clog2(WIDTH / 2 + 2);
    localparam logic [CW-1:0] LAST_SIGNED   = CW'(WIDTH / 2 - 1);
    localparam logic [CW-1:0] LAST_UNSIGNED = CW'(WIDTH / 2);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        CALC = 2'b01,
        DONE = 2'b10
    } state_t;

    state_t              state_r;
    state_t              state_next_s;
    logic                busy_r;
    logic                done_r;
    logic [2*WIDTH-1:0]  product_r;
    logic [AW-1:0]       a_r;
    logic [AW-1:0]       m_r;
    logic [QW-1:0]       q_r;
    logic                qm1_r;
    logic [CW-1:0]       cnt_r;
    logic                signed_r;

    logic [AW-1:0]       m_ext_s;
    logic [QW-1:0]       q_ext_s;
    logic [AW-1:0]       digit_s;
    logic [AW-1:0]       sum_s;
    logic [AW-1:0]       a_next_s;
    logic [QW-1:0]       q_next_s;
    logic                qm1_next_s;
    logic                last_iter_s;
    logic [2*WIDTH-1:0]  product_next_s;
    logic [2:0]          sel_s;

    // Operand extension: sign-extend normally, zero-extend in unsigned mode
    always_comb begin
        m_ext_s = {{(AW-WIDTH){Multiplicand[WIDTH-1]}}, Multiplicand};
        q_ext_s = {{(QW-WIDTH){Multiplier[WIDTH-1]}}, Multiplier};
`ifdef MULT_UNSIGNED_EN
        if (IsSigned) begin
            m_ext_s = {{(AW-WIDTH){Multiplicand[WIDTH-1]}}, Multiplicand};
            q_ext_s = {{(QW-WIDTH){Multiplier[WIDTH-1]}}, Multiplier};
        end else begin
            m_ext_s = {{(AW-WIDTH){1'b0}}, Multiplicand};
            q_ext_s = {{(QW-WIDTH){1'b0}}, Multiplier};
        end
`endif
    end

    // Booth recode of {Q[1],Q[0],q_-1}, accumulate, then arithmetic shift right by two
    always_comb begin
        digit_s = {AW{1'b0}};
        case ({q_r[1:0], qm1_r})
            3'b001, 3'b010: digit_s = m_r;
            3'b011:         digit_s = {m_r[AW-2:0], 1'b0};
            3'b100:         digit_s = ~{m_r[AW-2:0], 1'b0} + {{(AW-1){1'b0}}, 1'b1};
            3'b101, 3'b110: digit_s = ~m_r + {{(AW-1){1'b0}}, 1'b1};
            default:        digit_s = {AW{1'b0}};
        endcase
        sum_s      = a_r + digit_s;
        a_next_s   = {sum_s[AW-1], sum_s[AW-1], sum_s[AW-1:2]};
        q_next_s   = {sum_s[1:0], q_r[QW-1:2]};
        qm1_next_s = q_r[1];
    end

    // Iteration-end detection and result extraction from the post-shift value
    always_comb begin
        last_iter_s    = 1'b0;
        product_next_s = {(2*WIDTH){1'b0}};
`ifdef MULT_UNSIGNED_EN
        if (signed_r) begin
            last_iter_s    = (cnt_r == LAST_SIGNED);
            product_next_s = {a_next_s[WIDTH-1:0], q_next_s[QW-1:2]};
        end else begin
            last_iter_s    = (cnt_r == LAST_UNSIGNED);
            product_next_s = {a_next_s[WIDTH-3:0], q_next_s};
        end
`else
        if (signed_r) begin
            last_iter_s = (cnt_r == LAST_SIGNED);
        end else begin
            last_iter_s = (cnt_r == LAST_UNSIGNED);
        end
        product_next_s = {a_next_s[WIDTH-1:0], q_next_s};
`endif
    end

    // Next-state logic; Start is only honoured in IDLE
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (Start) begin
                    state_next_s = CALC;
                end else begin
                    state_next_s = IDLE;
                end
            end
            CALC: begin
                if (last_iter_s) begin
                    state_next_s = DONE;
                end else begin
                    state_next_s = CALC;
                end
            end
            DONE:    state_next_s = IDLE;
            default: state_next_s = IDLE;
        endcase
    end

    // State register with Busy registered alongside it
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_r <= IDLE;
            busy_r  <= 1'b0;
        end else begin
            state_r <= state_next_s;
            busy_r  <= (state_next_s != IDLE);
        end
    end

    // Datapath registers: operand capture, iteration, result and Done pulse
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            a_r       <= {AW{1'b0}};
            m_r       <= {AW{1'b0}};
            q_r       <= {QW{1'b0}};
            qm1_r     <= 1'b0;
            cnt_r     <= {CW{1'b0}};
            signed_r  <= 1'b1;
            done_r    <= 1'b0;
            product_r <= {(2*WIDTH){1'b0}};
        end else begin
            done_r <= 1'b0;
            if ((state_r == IDLE) && Start) begin
                a_r   <= {AW{1'b0}};
                m_r   <= m_ext_s;
                q_r   <= q_ext_s;
                qm1_r <= 1'b0;
                cnt_r <= {CW{1'b0}};
`ifdef MULT_UNSIGNED_EN
                signed_r <= IsSigned;
`else
                signed_r <= 1'b1;
`endif
            end else if (state_r == CALC) begin
                a_r   <= a_next_s;
                q_r   <= q_next_s;
                qm1_r <= qm1_next_s;
                cnt_r <= cnt_r + {{(CW-1){1'b0}}, 1'b1};
                if (last_iter_s) begin
                    product_r <= product_next_s;
                    done_r    <= 1'b1;
                end else begin
                    product_r <= product_r;
                end
            end else begin
                a_r <= a_r;
            end
        end
    end

    // Digit select follows the live Q/q_-1 bits, forced to zero outside CALC
    always_comb begin
        if (state_r == CALC) begin
            sel_s = {q_r[1:0], qm1_r};
        end else begin
            sel_s = 3'b000;
        end
    end

    assign Sel     = sel_s;
    assign Busy    = busy_r;
    assign Done    = done_r;
    assign Product = product_r;

endmodule

// File: doc/booth_seq_multiplier.md
BOOTH_SEQ_MULTIPLIER -- requirements
Module: booth_seq_multiplier

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, giving the operand width; legal values are even and at least 4.
REQ-002 The block SHALL have port Clk, input, 1 bit: single clock; all state changes on the rising edge.
REQ-003 The block SHALL have port Reset_n, input, 1 bit: reset, asynchronous and active-low.
REQ-004 The block SHALL have port Start, input, 1 bit: single-cycle request to begin a multiply.
REQ-005 The block SHALL have port Multiplicand, input, WIDTH bits: operand M, sampled on an accepted Start.
REQ-006 The block SHALL have port Multiplier, input, WIDTH bits: operand Q, sampled on an accepted Start.
REQ-007 The block SHALL have port Sel, output, 3 bits: the current Booth triplet {Q[1],Q[0],q_-1}, driven to the downstream 8-to-1 digit-select mux.
REQ-008 The block SHALL have port Busy, output, 1 bit: high while an operation is in progress.
REQ-009 The block SHALL have port Done, output, 1 bit: one-cycle pulse that marks Product valid.
REQ-010 The block SHALL have port Product, output, 2*WIDTH bits: the result.

Function
REQ-011 The block SHALL use three states: IDLE, CALC and DONE.
REQ-012 In IDLE, Start=1 SHALL load A=0, Q=Multiplier, q_-1=0 and M=Multiplicand, set the iteration counter to 0, and move to CALC.
REQ-013 While in CALC or DONE, Start SHALL be ignored, with no restart and no operand capture.
REQ-014 Each CALC cycle SHALL recode {Q[1],Q[0],q_-1} as 000/111->0, 001/010->+M, 011->+2M, 100->-2M, 101/110->-M.
REQ-015 Each CALC cycle SHALL add the recoded digit to A and then arithmetic-shift {A,Q,q_-1} right by 2 bits, in the same cycle.
REQ-016 A SHALL be WIDTH+2 bits, signed, and M SHALL be sign-extended, so that the -2M term for M=-2^(WIDTH-1) does not overflow.
REQ-017 CALC SHALL last exactly WIDTH/2 cycles, with the counter width at least ceil(log2(WIDTH/2+1)).
REQ-018 After the last CALC cycle the block SHALL move to DONE, register Product={A[WIDTH-1:0],Q} and assert Done.
REQ-019 DONE SHALL last exactly one cycle and then return to IDLE.
REQ-020 Latency SHALL be fixed: Done is high in cycle WIDTH/2+1 after the Start-accept edge, i.e. 17 cycles for WIDTH=32.
REQ-021 Busy SHALL be 1 in CALC and DONE and 0 in IDLE.
REQ-022 Product SHALL hold its value until the next completed operation.
REQ-023 Product SHALL not change on Start; it updates only on entry to DONE.
REQ-024 Sel SHALL be driven combinationally from the live Q/q_-1 registers, and SHALL be 000 when not in CALC.
REQ-025 Start asserted in the same cycle that DONE returns to IDLE SHALL be ignored; Start is sampled only while in IDLE.

Reset
REQ-026 When Reset_n=0, the block SHALL immediately, independent of Clk, set state=IDLE, A=0, Q=0, M=0, q_-1=0 and counter=0.
REQ-027 When Reset_n=0, the outputs SHALL immediately be Busy=0, Done=0, Product=0 and Sel=000.
REQ-028 Reset asserted mid-operation SHALL abort the operation, produce no Done pulse and clear Product to 0.
REQ-029 After reset is released, the first Start SHALL be accepted normally.

Configuration
REQ-030 When macro MULT_UNSIGNED_EN is defined, the block SHALL add input port IsSigned, 1 bit, sampled with the operands on an accepted Start.
REQ-031 When MULT_UNSIGNED_EN is defined and IsSigned=0, operands SHALL be zero-extended to WIDTH+2 bits, A SHALL widen to WIDTH+4 bits, and CALC SHALL run WIDTH/2+1 cycles, with latency one cycle longer.
REQ-032 When MULT_UNSIGNED_EN is defined and IsSigned=1, operation and latency SHALL be identical to REQ-014 through REQ-020.
REQ-033 When MULT_UNSIGNED_EN is undefined, port IsSigned SHALL be absent and every operation SHALL be signed with WIDTH/2 iterations.

Verification (WIDTH=32)
REQ-034 The bench SHALL check: Start with M=3, Q=5 -> Done exactly 17 cycles after the accept edge, Product=0x000000000000000F, Busy high for 17 cycles.
REQ-035 The bench SHALL check: M=0xFFFFFFF9 (-7), Q=6 -> Product=0xFFFFFFFFFFFFFFD6; M=Q=0xFFFFFFFF (-1) -> Product=0x0000000000000001.
REQ-036 The bench SHALL check: M=Q=0x80000000 -> Product=0x4000000000000000 (no accumulator overflow).
REQ-037 The bench SHALL check: Start pulsed during CALC with new operands -> ignored, first result delivered unchanged, no second Done.
REQ-038 The bench SHALL check: Reset_n driven low at CALC cycle 8 -> Busy, Done and Product go to 0 immediately; a new Start of 2*2 then gives Product=4.
REQ-039 The bench SHALL check, with MULT_UNSIGNED_EN defined, IsSigned=0 and M=Q=0xFFFFFFFF -> Product=0xFFFFFFFE00000001 after 18 cycles.
